button_conditioner: RTL

- Front end for the slot-machine controller: turns raw, bouncy, asynchronous push-button inputs into clean synchronous events.
- Produces per-button debounced level plus single-cycle press, release and long-press pulses.
- Channel 0 press_pulse drives the controller's start/stop input; channel 1 press_pulse drives its game-reset input. The controller then needs no edge-detect shift registers of its own.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_channel.sv | 151 +++++++++++++++
 rtl/button_conditioner.sv | 43 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button front end.
// Default constants assume a 50 MHz clk: 10 ms debounce, 1 s long press,
// 200 ms auto-repeat period.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_N_BTN             = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 500_000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES     = 10_000_000;
  localparam bit          DEF_BTN_ACTIVE_LOW    = 1'b1;

endpackage

// File: rtl/btn_channel.sv
// One button channel: polarity normalisation, 2-flop synchronizer,
// debounce state machine, hold timer and registered event pulses.
// Optional auto-repeat is built only when BTN_REPEAT_EN is defined;
// otherwise repeat_pulse is tied low and no repeat counter exists.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | released and stable, btn_level=0
// DB_PRESS   | synchronized input went pressed, waiting for it to settle
// HELD       | press accepted, btn_level=1, hold timer running
// DB_RELEASE | input went released, waiting to settle; hold timer frozen
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
  parameter bit          BTN_ACTIVE_LOW    = DEF_BTN_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES ||
      REPEAT_CYCLES < 1) begin : g_param_check
    $error("btn_channel: illegal timing parameters");
  end

  btn_state_t        state;
  logic              btn_norm;
  logic              sync_q1;
  logic              btn_sync;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  // After normalisation 1 always means pressed.
  assign btn_norm = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Two-flop synchronizer; resets to "not pressed".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1  <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync_q1  <= btn_norm;
      btn_sync <= sync_q1;
    end
  end

  // Debounce FSM, counters and registered level/pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_sync) begin
            state  <= DB_PRESS;
            db_cnt <= '0;
          end
        end
        DB_PRESS: begin
          if (!btn_sync) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state       <= HELD;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          if (!btn_sync) begin
            state  <= DB_RELEASE;
            db_cnt <= '0;
          end else if (hold_cnt != HOLD_MAX) begin
            // Saturating at HOLD_MAX makes the long press fire once per press.
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if (hold_cnt == HOLD_LAST) long_pulse <= 1'b1;
          end
        end
        DB_RELEASE: begin
          if (btn_sync) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;

  // Auto-repeat: counts held cycles after the long press; pauses while the
  // release is being debounced and clears once the channel is back in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (state == IDLE) begin
        rep_cnt <= '0;
      end else if (state == HELD && btn_sync && hold_cnt == HOLD_MAX) begin
        if (rep_cnt == REP_LAST) begin
          repeat_pulse <= 1'b1;
          rep_cnt      <= '0;
        end else begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: N_BTN independent channels turning raw, bouncy,
// asynchronous pins into a debounced level plus one-cycle press, release,
// long-press and (with BTN_REPEAT_EN defined) auto-repeat pulses.
// Channel 0 press_pulse feeds start/stop, channel 1 feeds game reset.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN             = DEF_N_BTN,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter bit          BTN_ACTIVE_LOW    = DEF_BTN_ACTIVE_LOW,
  parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  // One fully independent channel per button.
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES),
      .BTN_ACTIVE_LOW   (BTN_ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn_raw[gi]),
      .btn_level    (btn_level[gi]),
      .press_pulse  (press_pulse[gi]),
      .release_pulse(release_pulse[gi]),
      .long_pulse   (long_pulse[gi]),
      .repeat_pulse (repeat_pulse[gi])
    );
  end

endmodule
